// File: rtl/vram_arb.sv
// vram_arb: arbitrates the single video RAM port between the display fetch,
// which owns the port in pixel phase DISP_SLOT, and a CPU access sequencer.
// Optional build macro VRAM_ARB_STATS_EN adds a saturating stall counter;
// without it stall_cnt is tied to zero.
//
// state | meaning
// IDLE  | waiting for cpu_req
// ISSUE | CPU address/write on the RAM port; holds one cycle if slot is the display slot
// CAPT  | RAM read data valid; latch it for a read
// ACK   | cpu_ack pulse, then back to IDLE
module vram_arb #(
  parameter logic [2:0] DISP_SLOT = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  slot,
  input  logic [10:0] disp_addr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [10:0] ram_addr,
  output logic        ram_we_char,
  output logic        ram_we_attr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata_char,
  input  logic [7:0]  ram_rdata_attr,
  output logic        disp_valid,
  output logic [7:0]  disp_char,
  output logic [7:0]  disp_attr,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        disp_slot;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        fetch_q;
  logic [7:0]  disp_char_q, disp_attr_q;

  assign disp_slot = (slot == DISP_SLOT);

  // Next-state logic and drive of the shared RAM port; the display owns the port by default
  always_comb begin
    state_d     = state_q;
    ram_addr    = disp_addr;
    ram_we_char = 1'b0;
    ram_we_attr = 1'b0;
    ram_wdata   = 8'h00;
    cpu_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) state_d = ISSUE;
      end
      ISSUE: begin
        if (!disp_slot) begin
          ram_addr    = cpu_addr[11:1];
          ram_wdata   = cpu_wdata;
          ram_we_attr = cpu_we & cpu_addr[0];
          ram_we_char = cpu_we & ~cpu_addr[0];
          state_d     = CAPT;
        end
      end
      CAPT: begin
        state_d = ACK;
      end
      ACK: begin
        cpu_ack = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // CPU read data: RAM output is valid in CAPT for the address issued the cycle before
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    if (state_q == CAPT && !cpu_we) begin
      cpu_rdata_d = cpu_addr[0] ? ram_rdata_attr : ram_rdata_char;
    end
  end

  // State, CPU read data and display fetch registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cpu_rdata_q <= 8'h00;
      fetch_q     <= 1'b0;
      disp_char_q <= 8'h00;
      disp_attr_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cpu_rdata_q <= cpu_rdata_d;
      fetch_q     <= disp_slot;
      if (fetch_q) begin
        disp_char_q <= ram_rdata_char;
        disp_attr_q <= ram_rdata_attr;
      end
    end
  end

  // The fetched cell is passed straight through in the phase after the display slot
  // so disp_valid and its data coincide, then held until the next fetch.
  assign cpu_rdata  = cpu_rdata_q;
  assign disp_valid = fetch_q;
  assign disp_char  = fetch_q ? ram_rdata_char : disp_char_q;
  assign disp_attr  = fetch_q ? ram_rdata_attr : disp_attr_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles a CPU issue is held off by the display slot, saturating
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ISSUE && disp_slot && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= 16'h0000;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
